// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit: FSM states, mux selects,
// opcode/cmd/cond constants and the condition-code evaluator.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam state_t RESET_STATE = FETCH;
  localparam int     FLAG_W      = 4;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  // flags are {N, Z, C, V}
  function automatic logic cond_check(input logic [3:0] cond, input logic [FLAG_W-1:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: return z;
      COND_NE: return ~z;
      COND_CS: return c;
      COND_CC: return ~c;
      COND_MI: return n;
      COND_PL: return ~n;
      COND_VS: return v;
      COND_VC: return ~v;
      COND_HI: return c & ~z;
      COND_LS: return ~c | z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return ~z & (n == v);
      COND_LE: return z | (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/main_fsm.sv
// Fetch/decode/execute sequencer: state register plus raw, unconditioned per-state controls.
// One state per cycle; no backpressure, the datapath always completes a step in one cycle.
module main_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic       imm_bit,
  input  logic       load_bit,
  output logic       RegW,
  output logic       MemW,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       Branch,
  output logic       ALUOp,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc
);

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = FETCH;
    RegW      = 1'b0;
    MemW      = 1'b0;
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    case (state_q)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        NextPC    = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        case (Op)
          OP_MEM:  state_d = MEMADR;
          OP_DP:   state_d = imm_bit ? EXECI : EXECR;
          OP_BR:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM;
        state_d = load_bit ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECR: begin
        ALUOp   = 1'b1;
        state_d = ALUWB;
      end
      EXECI: begin
        ALUSrcB = SRCB_IMM;
        ALUOp   = 1'b1;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegW = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        Branch    = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset control: ALU decode, NZCV flags, condition check and write gating; 2-5 cycles
// per instruction, no backpressure. Define INSTR_CNT_EN to add the InstrCount fetch counter output.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUControl
`ifdef INSTR_CNT_EN
  ,
  output logic [31:0] InstrCount
`endif
);

  logic              reg_w, mem_w, ir_w, next_pc, branch, alu_op;
  logic [1:0]        flag_w;
  logic [FLAG_W-1:0] flags;
  logic              cond_ex, pcs, is_addsub;

  main_fsm u_fsm (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .imm_bit   (Funct[5]),
    .load_bit  (Funct[0]),
    .RegW      (reg_w),
    .MemW      (mem_w),
    .IRWrite   (ir_w),
    .NextPC    (next_pc),
    .Branch    (branch),
    .ALUOp     (alu_op),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc)
  );

  assign RegSrc = {Op == OP_MEM, Op == OP_BR};
  assign ImmSrc = Op;

  always_comb begin
    ALUControl = ALU_ADD;
    if (alu_op) begin
      case (Funct[4:1])
        CMD_ADD: ALUControl = ALU_ADD;
        CMD_SUB: ALUControl = ALU_SUB;
        CMD_AND: ALUControl = ALU_AND;
        CMD_ORR: ALUControl = ALU_ORR;
        default: ALUControl = ALU_ADD;
      endcase
    end
  end

  // C/V only carry meaning for arithmetic ops; logical ops leave them untouched
  assign is_addsub = (Funct[4:1] == CMD_ADD) || (Funct[4:1] == CMD_SUB);
  assign flag_w[1] = alu_op & Funct[0];
  assign flag_w[0] = alu_op & Funct[0] & is_addsub;

  assign cond_ex = cond_check(Cond, flags);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= '0;
    end else begin
      if (flag_w[1] & cond_ex) flags[3:2] <= ALUFlags[3:2];
      if (flag_w[0] & cond_ex) flags[1:0] <= ALUFlags[1:0];
    end
  end

  // strobes are masked by reset so an abandoned instruction leaves no partial writes
  assign pcs      = ((Rd == 4'hF) & reg_w) | branch;
  assign PCWrite  = reset & ((pcs & cond_ex) | next_pc);
  assign RegWrite = reset & reg_w & cond_ex;
  assign MemWrite = reset & mem_w & cond_ex;
  assign IRWrite  = reset & ir_w;

`ifdef INSTR_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       InstrCount <= '0;
    else if (next_pc) InstrCount <= InstrCount + 32'd1;
  end
`else
  // build without the fetch counter
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a stimulus process pushes per-cycle expectations from an
// instruction-level model; a monitor pops and compares them on every falling clock edge.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  Cond = '0, Rd = '0, ALUFlags = '0;
  logic [1:0]  Op = '0;
  logic [5:0]  Funct = '0;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, RegSrc, ImmSrc, ALUControl;
`ifdef INSTR_CNT_EN
  logic [31:0] InstrCount;
`endif

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .Cond       (Cond),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .RegSrc     (RegSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
`ifdef INSTR_CNT_EN
    ,
    .InstrCount (InstrCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, memw, regw, irw, adr, srca;
    logic [1:0] srcb, res, regsrc, immsrc, aluctl;
  } outs_t;

  typedef struct packed {
    outs_t       o;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          fn, fz, fc, fv;
  int unsigned icount = 0;
  bit          force_en = 0;
  logic [3:0]  force_val = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] cc);
    case (cc)
      4'h0: return fz;
      4'h1: return !fz;
      4'h2: return fc;
      4'h3: return !fc;
      4'h4: return fn;
      4'h5: return !fn;
      4'h6: return fv;
      4'h7: return !fv;
      4'h8: return fc && !fz;
      4'h9: return !fc || fz;
      4'hA: return fn == fv;
      4'hB: return fn != fv;
      4'hC: return !fz && (fn == fv);
      4'hD: return fz || (fn != fv);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 2'd0;
      4'b0010: return 2'd1;
      4'b0000: return 2'd2;
      4'b1100: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic exp_t base();
    exp_t e;
    e = '0;
    e.o.regsrc = {Op == 2'b01, Op == 2'b10};
    e.o.immsrc = Op;
    e.cnt = icount;
    return e;
  endfunction

  // mux selects shared by FETCH, DECODE and the reset view
  function automatic exp_t fetch_view();
    exp_t e;
    e = base();
    e.o.srca = 1'b1;
    e.o.srcb = 2'd2;
    e.o.res  = 2'd2;
    return e;
  endfunction

  task automatic emit(input exp_t e, input bit exec, input bit fetch);
    ALUFlags = force_en ? force_val : 4'($urandom);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (reset) begin
      if (exec && Funct[0] && cond_ok(Cond)) begin
        fn = ALUFlags[3];
        fz = ALUFlags[2];
        if (Funct[4:1] == 4'b0100 || Funct[4:1] == 4'b0010) begin
          fc = ALUFlags[1];
          fv = ALUFlags[0];
        end
      end
      if (fetch) icount++;
    end
  endtask

  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r);
    exp_t e;
    bit   ce;
    Cond = c; Op = o; Funct = f; Rd = r;
    e = fetch_view(); e.o.pcw = 1; e.o.irw = 1; emit(e, 0, 1);
    e = fetch_view(); emit(e, 0, 0);
    case (o)
      2'b01: begin
        e = base(); e.o.srcb = 2'd1; emit(e, 0, 0);
        if (f[0]) begin
          e = base(); e.o.adr = 1; emit(e, 0, 0);
          e = base(); e.o.res = 2'd1; ce = cond_ok(c);
          e.o.regw = ce; e.o.pcw = ce && (r == 4'hF); emit(e, 0, 0);
        end else begin
          e = base(); e.o.adr = 1; e.o.memw = cond_ok(c); emit(e, 0, 0);
        end
      end
      2'b00: begin
        e = base(); e.o.srcb = f[5] ? 2'd1 : 2'd0; e.o.aluctl = alu_of(f[4:1]); emit(e, 1, 0);
        e = base(); ce = cond_ok(c);
        e.o.regw = ce; e.o.pcw = ce && (r == 4'hF); emit(e, 0, 0);
      end
      2'b10: begin
        e = base(); e.o.srcb = 2'd1; e.o.res = 2'd2; e.o.pcw = cond_ok(c); emit(e, 0, 0);
      end
      default: ;
    endcase
  endtask

  task automatic forced(input logic [3:0] fl, input logic [3:0] c, input logic [5:0] f);
    force_en = 1; force_val = fl;
    run_instr(c, 2'b00, f, 4'd5);
    force_en = 0;
  endtask

  task automatic reset_during_str();
    exp_t e;
    Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'd3;
    e = fetch_view(); e.o.pcw = 1; e.o.irw = 1; emit(e, 0, 1);
    e = fetch_view(); emit(e, 0, 0);
    e = base(); e.o.srcb = 2'd1; emit(e, 0, 0);
    // now in the store-write cycle
    ALUFlags = 4'($urandom);
    check("memw_before_reset", 64'(MemWrite), 64'd1);
    reset = 1'b0;
    #1;
    check("memw_drop_on_reset", 64'(MemWrite), 64'd0);
    fn = 0; fz = 0; fc = 0; fv = 0; icount = 0;
    sb.push_back(fetch_view());
    @(posedge clk);
    #1;
    emit(fetch_view(), 0, 0);
    reset = 1'b1;
  endtask

  initial begin : monitor
    exp_t  e;
    outs_t act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = '{PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, RegSrc, ImmSrc, ALUControl};
        check("ctrl_outputs", 64'(act), 64'(e.o));
`ifdef INSTR_CNT_EN
        check("instr_count", 64'(InstrCount), 64'(e.cnt));
`endif
      end
    end
  end

  initial begin : stimulus
    fn = 0; fz = 0; fc = 0; fv = 0;
    @(posedge clk);
    #1;
    repeat (3) emit(fetch_view(), 0, 0);
    reset = 1'b1;

    run_instr(4'hE, 2'b00, 6'b001000, 4'd1);   // ADD r1
    run_instr(4'hE, 2'b01, 6'b011001, 4'd2);   // LDR
    forced(4'b0100, 4'hE, 6'b000101);          // SUBS -> Z
    run_instr(4'h0, 2'b01, 6'b011000, 4'd3);   // STREQ taken
    forced(4'b0000, 4'hE, 6'b000101);
    run_instr(4'h0, 2'b01, 6'b011000, 4'd3);   // STREQ suppressed
    forced(4'b0100, 4'hE, 6'b000101);
    run_instr(4'h1, 2'b10, 6'b100000, 4'd0);   // BNE not taken
    forced(4'b0000, 4'hE, 6'b000101);
    run_instr(4'h1, 2'b10, 6'b100000, 4'd0);   // BNE taken
    run_instr(4'hE, 2'b00, 6'b001000, 4'hF);   // ADD pc
    forced(4'b0011, 4'hE, 6'b000101);          // C=1 V=1
    forced(4'b1100, 4'hE, 6'b000001);          // ANDS: NZ only
    run_instr(4'h2, 2'b01, 6'b011000, 4'd3);   // STRCS
    run_instr(4'h6, 2'b01, 6'b011000, 4'd3);   // STRVS
    run_instr(4'h0, 2'b01, 6'b011000, 4'd3);   // STREQ
    run_instr(4'hF, 2'b00, 6'b001000, 4'd1);   // never-condition
    run_instr(4'hE, 2'b11, 6'b111111, 4'hF);   // undefined opcode
    reset_during_str();
    run_instr(4'h0, 2'b01, 6'b011000, 4'd3);   // flags cleared: EQ fails

    for (int i = 0; i < 300; i++) begin
      run_instr(4'($urandom), 2'($urandom), 6'($urandom),
                ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom));
    end

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
